sha256_mem_responder: RTL and testbench



---
 rtl/sha256_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_mem_responder.sv
// =====================================================================
// Module : sha256_mem_responder
// Brief  : Host-side RAM, start and done responder for a SHA-256 engine.
// Rev    : 1.0  initial release
// =====================================================================
`default_nettype none

module sha256_mem_responder #(
  parameter int          NUM_OF_WORDS   = 20,
  parameter int          DEPTH          = 1024,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0100,
  parameter int          HASH_WORDS     = 8,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  input  logic [31:0] host_in_data,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic [31:0] host_out_data,
  output logic        host_out_last,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        addr_err,
  output logic        timeout
);

  localparam int          c_aw    = $clog2(DEPTH);
  localparam int          c_cw    = $clog2(NUM_OF_WORDS) + 1;
  localparam int          c_iw    = $clog2(HASH_WORDS) + 1;
  localparam int          c_tw    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [31:0] c_depth = 32'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_OF_WORDS < 1 || HASH_WORDS < 1 ||
      TIMEOUT_CYCLES < 1 || int'(MSG_ADDR) + NUM_OF_WORDS > DEPTH ||
      int'(OUT_ADDR) + HASH_WORDS > DEPTH) begin : g_param_check
    $fatal(1, "sha256_mem_responder: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DUMP      = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_run, r_out_valid, r_addr_err, r_timeout;
  logic [c_cw-1:0] r_cnt;
  logic [c_iw-1:0] r_idx;
  logic [c_tw-1:0] r_timer;
  logic [31:0]     r_out_data, r_rd_data;
  logic [31:0]     r_mem [DEPTH];

  logic            w_in_beat, w_eng_act, w_eng_oob, w_last_cnt, w_last_idx;
  logic            w_accept, w_tmo, w_we;
  logic [c_cw-1:0] w_load_off;
  logic [c_aw-1:0] w_wr_idx, w_out_idx, w_eng_idx;
  logic [31:0]     w_wr_data;

  // r_run keeps host_in_ready low while reset is held and for the first cycle after it
  assign host_in_ready = r_run && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_in_beat     = host_in_valid && host_in_ready;
  assign w_eng_act     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_eng_oob     = {16'd0, mem_addr} >= c_depth;
  assign w_last_cnt    = r_cnt == c_cw'(NUM_OF_WORDS - 1);
  assign w_last_idx    = r_idx == c_iw'(HASH_WORDS - 1);
  assign w_accept      = r_out_valid && host_out_ready;
  assign w_tmo         = r_timer == c_tw'(TIMEOUT_CYCLES - 1);

  assign w_load_off = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_eng_idx  = mem_addr[c_aw-1:0];
  assign w_wr_idx   = w_in_beat ? c_aw'(MSG_ADDR + 16'(w_load_off)) : w_eng_idx;
  assign w_out_idx  = c_aw'(OUT_ADDR + 16'(r_idx));
  assign w_wr_data  = w_in_beat ? host_in_data : mem_write_data;
  assign w_we       = w_in_beat || (w_eng_act && mem_we && !w_eng_oob);

  assign host_out_valid = r_out_valid;
  assign host_out_data  = r_out_data;
  assign host_out_last  = r_out_valid && w_last_idx;
  assign sha_start      = r_state == S_KICK;
  assign busy           = r_state != S_IDLE;
  assign message_addr   = MSG_ADDR;
  assign output_addr    = OUT_ADDR;
  assign mem_read_data  = r_rd_data;
  assign addr_err       = r_addr_err;
  assign timeout        = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_in_beat) w_state_nxt = (NUM_OF_WORDS == 1) ? S_KICK : S_LOAD;
      S_LOAD:      if (w_in_beat && w_last_cnt) w_state_nxt = S_KICK;
      S_KICK:      w_state_nxt = S_WAIT_BUSY;
      // A normal handshake on the final timer cycle still wins over the timeout
      S_WAIT_BUSY: if (!sha_done) w_state_nxt = S_WAIT_DONE;
                   else if (w_tmo) w_state_nxt = S_IDLE;
      S_WAIT_DONE: if (sha_done) w_state_nxt = S_DUMP;
                   else if (w_tmo) w_state_nxt = S_IDLE;
      S_DUMP:      if (w_accept && w_last_idx) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run       <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rd_data   <= '0;
      r_addr_err  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_beat) begin
        r_cnt <= w_load_off + c_cw'(1);
        if (r_state == S_IDLE) begin
          r_addr_err <= 1'b0;
          r_timeout  <= 1'b0;
        end
      end
      if (r_state == S_KICK) begin
        r_cnt   <= '0;
        r_timer <= '0;
      end
      if (w_eng_act) begin
        r_timer <= r_timer + c_tw'(1);
        if (w_eng_oob) begin
          r_rd_data  <= '0;
          r_addr_err <= 1'b1;
        end else begin
          r_rd_data <= r_mem[w_eng_idx];
        end
        if (w_state_nxt == S_IDLE) r_timeout <= 1'b1;
      end
      if (r_state == S_WAIT_DONE && sha_done) r_idx <= '0;
      // Issue cycle fetches the word, the next cycle presents it until accepted
      if (r_state == S_DUMP) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[w_out_idx];
        end else if (host_out_ready) begin
          r_out_valid <= 1'b0;
          r_idx       <= r_idx + c_iw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_idx] <= w_wr_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_mem_responder.sv
// =====================================================================
// Module : tb_sha256_mem_responder
// Brief  : Directed bench with a behavioural SHA-256 mock engine.
// Rev    : 1.0  initial release
// =====================================================================
`default_nettype none

module tb_sha256_mem_responder;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic        clk, reset_n;
  logic        host_in_valid, host_in_ready;
  logic [31:0] host_in_data;
  logic        host_out_valid, host_out_ready, host_out_last;
  logic [31:0] host_out_data;
  logic        sha_start, sha_done;
  logic [15:0] message_addr, output_addr;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        busy, addr_err, timeout;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] msg_a [20];
  logic [31:0] msg_b [20];
  logic [31:0] cur   [20];
  logic [31:0] eng_rd[20];

  sha256_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .host_out_data(host_out_data), .host_out_last(host_out_last),
    .sha_start(sha_start), .sha_done(sha_done),
    .message_addr(message_addr), .output_addr(output_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy), .addr_err(addr_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Standard SHA-256 of a 20-word (640-bit) message: two padded blocks
  function automatic logic [255:0] sha256_20(input logic [31:0] m [20]);
    logic [31:0] blk [32];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 32; i++) blk[i] = 32'h0;
    for (int i = 0; i < 20; i++) blk[i] = m[i];
    blk[20] = 32'h80000000;
    blk[31] = 32'd640;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bi = 0; bi < 2; bi++) begin
      for (int t = 0; t < 16; t++) w[t] = blk[bi*16 + t];
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  task automatic load_msg(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      host_in_valid = 1'b1;
      host_in_data  = cur[i];
      @(negedge clk);
    end
    host_in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!sha_start && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(sha_start), 32'd1);
  endtask

  // mode 1: read-before-write probe, mode 2: out-of-range access probe
  task automatic run_engine(input int mode);
    logic [255:0] h, hx;
    wait_start();
    sha_done = 1'b0;
    @(negedge clk);
    check("start_width", 32'(sha_start), 32'd0);
    check("in_ready_wait", 32'(host_in_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      mem_addr = 16'(i);
      @(negedge clk);
      check("eng_rd", mem_read_data, cur[i]);
      eng_rd[i] = mem_read_data;
    end
    if (mode == 1) begin
      mem_we = 1'b1; mem_addr = 16'd300; mem_write_data = 32'h11111111;
      @(negedge clk);
      mem_write_data = 32'h22222222;
      @(negedge clk);
      check("rbw_old", mem_read_data, 32'h11111111);
      mem_we = 1'b0;
      @(negedge clk);
      check("rbw_new", mem_read_data, 32'h22222222);
    end
    if (mode == 2) begin
      check("err_pre", 32'(addr_err), 32'd0);
      mem_we = 1'b1; mem_addr = 16'h0400; mem_write_data = 32'hDEADBEEF;
      @(negedge clk);
      check("err_set", 32'(addr_err), 32'd1);
      check("err_rd0_w", mem_read_data, 32'd0);
      mem_we = 1'b0; mem_addr = 16'h0000;
      @(negedge clk);
      check("no_alias", mem_read_data, cur[0]);
      mem_addr = 16'hFFFF;
      @(negedge clk);
      check("err_rd0", mem_read_data, 32'd0);
    end
    h  = sha256_20(eng_rd);
    hx = sha256_20(cur);
    for (int i = 0; i < 8; i++) begin
      mem_we = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_write_data = h[255 - 32*i -: 32];
      @(negedge clk);
    end
    mem_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_addr = 16'h0100 + 16'(i);
      @(negedge clk);
      check("ram_hash", mem_read_data, hx[255 - 32*i -: 32]);
    end
    mem_addr = 16'h0000;
    sha_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic dump(input logic [255:0] exp, input bit stall);
    int          got = 0;
    int          cyc = 0;
    int          step = 0;
    bit          held_v = 1'b0;
    logic [31:0] held = 32'h0;
    logic [3:0]  pat = 4'b1001;
    while (got < 8 && cyc < 200) begin
      host_out_ready = stall ? pat[step % 4] : 1'b1;
      if (host_out_valid) begin
        if (held_v) check("hold_data", host_out_data, held);
        step++;
        if (host_out_ready) begin
          check("hash_word", host_out_data, exp[255 - 32*got -: 32]);
          check("last_flag", 32'(host_out_last), 32'(got == 7));
          got++;
          held_v = 1'b0;
        end else begin
          held   = host_out_data;
          held_v = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    host_out_ready = 1'b0;
    check("dump_count", 32'(got), 32'd8);
    check("busy_after_last", 32'(busy), 32'd0);
    check("valid_after_last", 32'(host_out_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; host_in_valid = 1'b0; host_in_data = 32'h0; host_out_ready = 1'b0;
    sha_done = 1'b1; mem_we = 1'b0; mem_addr = 16'h0; mem_write_data = 32'h0;
    for (int i = 0; i < 20; i++) begin
      msg_a[i] = 32'(i + 1);
      msg_b[i] = 32'h01234675;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(host_in_ready), 32'd0);
    check("rst_out_valid", 32'(host_out_valid), 32'd0);
    check("rst_start", 32'(sha_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", mem_read_data, 32'd0);
    check("rst_flags", {30'd0, addr_err, timeout}, 32'd0);
    check("msg_addr", 32'(message_addr), 32'h0000);
    check("out_addr", 32'(output_addr), 32'h0100);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(host_in_ready), 32'd1);

    // Job A: ascending words, start-pulse timing, read-before-write, free-running dump
    cur = msg_a;
    load_msg(0, 20);
    check("start_pulse", 32'(sha_start), 32'd1);
    check("busy_kick", 32'(busy), 32'd1);
    run_engine(1);
    dump(sha256_20(msg_a), 1'b0);

    // Job B: repeated word, out-of-range accesses, stalled dump
    cur = msg_b;
    load_msg(0, 20);
    run_engine(2);
    dump(sha256_20(msg_b), 1'b1);

    // Job C: engine never drops done, expect timeout after 4096 wait cycles
    cur = msg_a;
    load_msg(0, 1);
    check("err_cleared", 32'(addr_err), 32'd0);
    load_msg(1, 19);
    wait_start();
    repeat (4096) @(negedge clk);
    check("tmo_not_yet", 32'(timeout), 32'd0);
    check("tmo_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_set", 32'(timeout), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_no_valid", 32'(host_out_valid), 32'd0);

    // Job D: timeout cleared by first beat, then reset during the 10th beat
    load_msg(0, 1);
    check("tmo_cleared", 32'(timeout), 32'd0);
    load_msg(1, 8);
    host_in_valid = 1'b1;
    host_in_data  = cur[9];
    #1 reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(host_in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_start", 32'(sha_start), 32'd0);
    check("arst_rd", mem_read_data, 32'd0);
    @(negedge clk);
    host_in_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Job E: reset while a hash word is presented
    cur = msg_b;
    load_msg(0, 20);
    run_engine(0);
    for (int n = 0; n < 20 && !host_out_valid; n++) @(negedge clk);
    check("dump_valid_seen", 32'(host_out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(host_out_valid), 32'd0);
    check("arst_busy_dump", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Job F: clean job after the resets
    cur = msg_a;
    load_msg(0, 20);
    run_engine(0);
    dump(sha256_20(msg_a), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
